mem_interface: RTL

- Memory-side stage of the multicycle RV32I core. It consumes the control unit's IRWrite, MemWrite, AdSrc and MemRead strobes and turns each one into a single transaction on a variable-latency valid/ready memory bus.
- It owns the instruction register (with its OldPC) and the memory data register.
- It drives o_stall back to the control unit, which holds its FSM state while o_stall is high.

---
 rtl/mem_interface.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_interface.sv
// mem_interface: memory-side stage of the multicycle RV32I core; turns
// IRWrite/MemWrite/MemRead strobes into one valid/ready bus transaction.
// Owns the instruction register (+OldPC) and the memory data register.
// Ports: i_clk/i_rst (async, active-high); control strobes i_IRWrite,
//   i_MemWrite, i_MemRead, i_AdSrc; operands i_pc, i_result, i_wdata,
//   i_funct3; bus o_bus_req/we/addr/wdata/be, i_bus_ready/rvalid/rdata;
//   results o_instr, o_old_pc, o_data; status o_stall, o_done,
//   o_misalign, o_bus_err.
// Optional: define MEM_TIMEOUT_EN to abort after TIMEOUT cycles.

module mem_interface #(
    parameter int          ADDR_W    = 32,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_IRWrite,
    input  logic              i_MemWrite,
    input  logic              i_MemRead,
    input  logic              i_AdSrc,
    input  logic [31:0]       i_pc,
    input  logic [31:0]       i_result,
    input  logic [31:0]       i_wdata,
    input  logic [2:0]        i_funct3,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [31:0]       o_bus_wdata,
    output logic [3:0]        o_bus_be,
    input  logic              i_bus_ready,
    input  logic              i_bus_rvalid,
    input  logic [31:0]       i_bus_rdata,
    output logic [31:0]       o_instr,
    output logic [31:0]       o_old_pc,
    output logic [31:0]       o_data,
    output logic              o_stall,
    output logic              o_done,
    output logic              o_misalign,
    output logic              o_bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RD,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              fetch_q, fetch_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       old_pc_q, old_pc_d;
    logic [31:0]       data_q, data_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    logic        start;
    logic        is_fetch;
    logic        is_store;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic        misal;
    logic [3:0]  sel_be;
    logic [31:0] sel_wdata;
    logic        capture;

    // Fetch wins over store, store over load.
    assign start    = i_IRWrite | i_MemWrite | i_MemRead;
    assign is_fetch = i_IRWrite;
    assign is_store = ~i_IRWrite & i_MemWrite;
    assign sel_addr = i_AdSrc ? i_result : i_pc;
    assign sel_size = is_fetch ? 2'b10 : i_funct3[1:0];

    // Size code 2'b11 is not a legal RV32I access; it behaves as a word.
    assign misal = ((sel_size == 2'b01) & sel_addr[0]) |
                   (sel_size[1] & (sel_addr[1:0] != 2'b00));

    always_comb begin
        sel_be    = 4'b1111;
        sel_wdata = i_wdata;
        if (is_store) begin
            case (sel_size)
                2'b00: begin
                    sel_be    = 4'b0001 << sel_addr[1:0];
                    sel_wdata = {4{i_wdata[7:0]}};
                end
                2'b01: begin
                    sel_be    = 4'b0011 << sel_addr[1:0];
                    sel_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    sel_be    = 4'b1111;
                    sel_wdata = i_wdata;
                end
            endcase
        end
    end

    function automatic logic [31:0] load_ext(
        input logic [31:0] rdata,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [31:0] lane;
        lane = rdata >> {off, 3'b000};
        case (size)
            2'b00:   load_ext = {{24{lane[7] & ~uns}}, lane[7:0]};
            2'b01:   load_ext = {{16{lane[15] & ~uns}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        fetch_d    = fetch_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        instr_d    = instr_q;
        old_pc_d   = old_pc_q;
        data_d     = data_q;
        o_bus_req  = 1'b0;
        o_stall    = 1'b0;
        o_done     = 1'b0;
        o_misalign = 1'b0;
        capture    = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (misal) begin
                        o_misalign = 1'b1;
                    end else begin
                        o_stall = 1'b1;
                        addr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
                        we_d    = is_store;
                        be_d    = sel_be;
                        wdata_d = sel_wdata;
                        fetch_d = is_fetch;
                        size_d  = sel_size;
                        uns_d   = ~is_fetch & i_funct3[2];
                        off_d   = sel_addr[1:0];
                        state_d = REQ;
`ifdef MEM_TIMEOUT_EN
                        // Counts cycles elapsed since accept.
                        cnt_d   = CNT_W'(1);
                        err_d   = 1'b0;
`endif
                    end
                end
            end
            REQ: begin
                o_bus_req = 1'b1;
                o_stall   = 1'b1;
                if (i_bus_ready) begin
                    if (we_q) begin
                        state_d = DONE;
                    end else if (i_bus_rvalid) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                o_stall = 1'b1;
                if (i_bus_rvalid) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef MEM_TIMEOUT_EN
        // A real completion in the last allowed cycle wins over the abort.
        if (((state_q == REQ) || (state_q == WAIT_RD)) &&
            (state_d != DONE)) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                state_d = DONE;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
        if (capture) begin
            if (fetch_q) begin
                instr_d  = i_bus_rdata;
                old_pc_d = 32'(addr_q);
            end else begin
                data_d = load_ext(i_bus_rdata, off_q, size_q, uns_q);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= 4'b0000;
            wdata_q  <= '0;
            fetch_q  <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            off_q    <= 2'b00;
            instr_q  <= NOP_INSTR;
            old_pc_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            fetch_q  <= fetch_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            off_q    <= off_d;
            instr_q  <= instr_d;
            old_pc_q <= old_pc_d;
            data_q   <= data_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_bus_err = (state_q == DONE) & err_q;
`else
    assign o_bus_err = 1'b0;
`endif

    assign o_bus_we    = we_q;
    assign o_bus_addr  = addr_q;
    assign o_bus_wdata = wdata_q;
    assign o_bus_be    = be_q;
    assign o_instr     = instr_q;
    assign o_old_pc    = old_pc_q;
    assign o_data      = data_q;

endmodule
